// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and constants for the CPU-to-BRAM/MMIO bridge.
// Holds the access-size encoding, the FSM state encoding and the MMIO map.
package mem_bridge_pkg;

  // Access size as driven by the CPU on cpu_size
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Bridge control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

  // MMIO window and register offsets (byte addresses)
  localparam logic [63:0] MMIO_BASE    = 64'h0000_0000_1000_0000;
  localparam logic [63:0] MMIO_LED_OFF = 64'h0000_0000_0000_0000;
  localparam logic [63:0] MMIO_SW_OFF  = 64'h0000_0000_0000_0008;

endpackage

// File: rtl/mem_bridge_align.sv
// mem_bridge_align: purely combinational lane logic for the bridge.
// Produces byte strobes and the lane-shifted store word for the 64-bit BRAM,
// extracts and sign/zero-extends a load from a 64-bit BRAM word, and flags
// accesses whose byte offset is not a multiple of their size.
module mem_bridge_align
  import mem_bridge_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size,
  input  logic [2:0]      lane,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] st_data,
  input  logic [63:0]     ld_word,
  output logic            misaligned,
  output logic [7:0]      strobe,
  output logic [63:0]     st_lane,
  output logic [XLEN-1:0] ld_data
);

  size_e       sz;
  logic [63:0] st_wide;
  logic [63:0] ld_shift;
  logic [63:0] ld_ext;

  assign sz       = size_e'(size);
  assign st_wide  = 64'(st_data);
  // Store data arrives right-aligned; move it up to its byte lane.
  assign st_lane  = st_wide << {lane, 3'b000};
  // Load data is brought down to bit 0 before masking and extension.
  assign ld_shift = ld_word >> {lane, 3'b000};

  // Per-size strobe pattern, alignment check and load extension
  always_comb begin
    misaligned = 1'b0;
    strobe     = 8'h00;
    ld_ext     = 64'h0;
    case (sz)
      SZ_BYTE: begin
        strobe = 8'h01 << lane;
        ld_ext = is_unsigned ? {56'h0, ld_shift[7:0]}
                             : {{56{ld_shift[7]}}, ld_shift[7:0]};
      end
      SZ_HALF: begin
        misaligned = lane[0];
        strobe     = 8'h03 << lane;
        ld_ext     = is_unsigned ? {48'h0, ld_shift[15:0]}
                                 : {{48{ld_shift[15]}}, ld_shift[15:0]};
      end
      SZ_WORD: begin
        misaligned = |lane[1:0];
        strobe     = 8'h0F << lane;
        ld_ext     = is_unsigned ? {32'h0, ld_shift[31:0]}
                                 : {{32{ld_shift[31]}}, ld_shift[31:0]};
      end
      default: begin
        misaligned = |lane;
        strobe     = 8'hFF;
        ld_ext     = ld_shift;
      end
    endcase
  end

  assign ld_data = XLEN'(ld_ext);

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: connects the CPU load/store port to a 64-bit-wide block RAM and
// a small MMIO window (LED register, synchronised switches).
// The accept cycle is the IDLE cycle in which a request is seen: BRAM enable,
// strobes, address and data are driven combinationally in that cycle and are
// forced to zero at all other times (including while rst is low).
// Optional feature: define MEM_BRIDGE_MMIO_EN to enable the MMIO window;
// without it MMIO addresses fault, led_out is 0 and sw_in is ignored.
// RD_LAT must lie in 1..3 (the wait counter is two bits wide).
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int BRAM_AW = 14,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memory_re,
  input  logic               memory_we,
  input  logic [XLEN-1:0]    cpu_addr,
  input  logic [XLEN-1:0]    cpu_wdata,
  input  logic [1:0]         cpu_size,
  input  logic               cpu_unsigned,
  output logic [XLEN-1:0]    cpu_rdata,
  output logic               mem_ready,
  output logic               bus_err,
  output logic               bram_en,
  output logic [7:0]         bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [63:0]        bram_wdata,
  input  logic [63:0]        bram_rdata,
  output logic [15:0]        led_out,
  input  logic [15:0]        sw_in
);

  localparam logic [1:0] RD_LAT_M1 = 2'(RD_LAT - 1);

  state_e          state_reg;
  state_e          state_next;
  logic [1:0]      cnt_reg;
  logic            live_reg;
  logic [1:0]      size_reg;
  logic [2:0]      lane_reg;
  logic            uns_reg;
  logic [XLEN-1:0] cpu_rdata_reg;
  logic            mem_ready_reg;
  logic            bus_err_reg;

  logic            req;
  logic            is_store;
  logic            is_load;
  logic            in_bram;
  logic            hit_led;
  logic            hit_sw;
  logic            fault;
  logic            bram_acc;
  logic            mmio_acc;
  logic [15:0]     mmio_rdata;
  logic            rd_done;

  logic [1:0]      al_size;
  logic [2:0]      al_lane;
  logic            al_uns;
  logic            misaligned;
  logic [7:0]      strobe;
  logic [63:0]     st_lane;
  logic [XLEN-1:0] ld_data;

  // A store wins over a simultaneous load; the load is simply dropped.
  assign is_store = memory_we;
  assign is_load  = memory_re & ~memory_we;
  // live_reg keeps the accept path quiet while rst is low and for the first
  // edge after release, so BRAM controls are zero throughout reset.
  assign req      = (state_reg == IDLE) & live_reg & (memory_re | memory_we);
  assign in_bram  = (cpu_addr >> (BRAM_AW + 3)) == '0;
  assign rd_done  = (state_reg == RD_WAIT) & (cnt_reg == 2'd0);

  // In IDLE the lane logic sees the live request; afterwards it sees the
  // captured size/offset so the returning BRAM word can be extracted.
  assign al_size = (state_reg == IDLE) ? cpu_size     : size_reg;
  assign al_lane = (state_reg == IDLE) ? cpu_addr[2:0] : lane_reg;
  assign al_uns  = (state_reg == IDLE) ? cpu_unsigned : uns_reg;

  mem_bridge_align #(
    .XLEN(XLEN)
  ) u_align (
    .size       (al_size),
    .lane       (al_lane),
    .is_unsigned(al_uns),
    .st_data    (cpu_wdata),
    .ld_word    (bram_rdata),
    .misaligned (misaligned),
    .strobe     (strobe),
    .st_lane    (st_lane),
    .ld_data    (ld_data)
  );

`ifdef MEM_BRIDGE_MMIO_EN
  logic [15:0] led_reg;
  logic [15:0] sw_meta_reg;
  logic [15:0] sw_sync_reg;

  assign hit_led    = cpu_addr == XLEN'(MMIO_BASE + MMIO_LED_OFF);
  assign hit_sw     = cpu_addr == XLEN'(MMIO_BASE + MMIO_SW_OFF);
  assign mmio_rdata = hit_led ? led_reg : sw_sync_reg;
  assign led_out    = led_reg;

  // Two-flop synchroniser for the raw board switches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_reg <= 16'h0;
      sw_sync_reg <= 16'h0;
    end else begin
      sw_meta_reg <= sw_in;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // LED register written by stores to its offset (low 16 bits of the data)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_reg <= 16'h0;
    end else if (mmio_acc && is_store && hit_led) begin
      led_reg <= cpu_wdata[15:0];
    end
  end
`else
  logic sw_unused;

  assign hit_led    = 1'b0;
  assign hit_sw     = 1'b0;
  assign mmio_rdata = 16'h0;
  assign led_out    = 16'h0;
  assign sw_unused  = ^sw_in;
`endif

  // Misaligned or unmapped requests fault without touching BRAM or MMIO.
  assign fault    = req & (misaligned | ~(in_bram | hit_led | hit_sw));
  assign bram_acc = req & ~fault & in_bram;
  assign mmio_acc = req & ~fault & ~in_bram;

  assign bram_en    = bram_acc;
  assign bram_we    = (bram_acc & is_store) ? strobe : 8'h00;
  assign bram_addr  = bram_acc ? cpu_addr[BRAM_AW+2:3] : '0;
  assign bram_wdata = (bram_acc & is_store) ? st_lane : 64'h0;

  assign cpu_rdata = cpu_rdata_reg;
  assign mem_ready = mem_ready_reg;
  assign bus_err   = bus_err_reg;

  // Next-state: BRAM loads wait for the RAM, everything else responds next cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = (bram_acc & is_load) ? RD_WAIT : RESP;
      RD_WAIT: if (cnt_reg == 2'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, latency counter and captured request attributes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      live_reg  <= 1'b0;
      cnt_reg   <= 2'd0;
      size_reg  <= 2'd0;
      lane_reg  <= 3'd0;
      uns_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
      if (req) begin
        cnt_reg  <= RD_LAT_M1;
        size_reg <= cpu_size;
        lane_reg <= cpu_addr[2:0];
        uns_reg  <= cpu_unsigned;
      end else if ((state_reg == RD_WAIT) && (cnt_reg != 2'd0)) begin
        cnt_reg <= cnt_reg - 2'd1;
      end
    end
  end

  // Response flags are high exactly while the FSM sits in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ready_reg <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      mem_ready_reg <= (state_next == RESP);
      bus_err_reg   <= fault;
    end
  end

  // Load data register: updated by loads and faults, untouched by stores
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_reg <= '0;
    end else if (fault) begin
      cpu_rdata_reg <= '0;
    end else if (mmio_acc && is_load) begin
      cpu_rdata_reg <= XLEN'(mmio_rdata);
    end else if (rd_done) begin
      cpu_rdata_reg <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed stimulus with a scoreboard. The driver pushes the
// expected BRAM accept and the expected response into queues; a negedge
// monitor pops and compares whenever bram_en or mem_ready is seen.
`timescale 1ns/1ps
module tb_mem_bridge;

  localparam int XLEN    = 64;
  localparam int BRAM_AW = 14;
  localparam int RD_LAT  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               memory_re = 1'b0;
  logic               memory_we = 1'b0;
  logic [XLEN-1:0]    cpu_addr = '0;
  logic [XLEN-1:0]    cpu_wdata = '0;
  logic [1:0]         cpu_size = 2'd0;
  logic               cpu_unsigned = 1'b0;
  logic [XLEN-1:0]    cpu_rdata;
  logic               mem_ready;
  logic               bus_err;
  logic               bram_en;
  logic [7:0]         bram_we;
  logic [BRAM_AW-1:0] bram_addr;
  logic [63:0]        bram_wdata;
  logic [63:0]        bram_rdata;
  logic [15:0]        led_out;
  logic [15:0]        sw_in = 16'h0;

  always #5 clk = ~clk;

  mem_bridge #(
    .XLEN(XLEN), .BRAM_AW(BRAM_AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .memory_re(memory_re), .memory_we(memory_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_rdata(cpu_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .led_out(led_out), .sw_in(sw_in)
  );

  // Simple BRAM model: byte-strobed write, read-first, RD_LAT registered stages
  logic [63:0] bram_mem [0:1023];
  logic [63:0] rd_pipe  [0:RD_LAT-1];
  assign bram_rdata = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 8; b++)
        if (bram_we[b]) bram_mem[bram_addr[9:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
      rd_pipe[0] <= bram_mem[bram_addr[9:0]];
    end
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  typedef struct {
    string       name;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    string        name;
    logic [7:0]   we;
    logic [13:0]  addr;
    logic [63:0]  wdata;
  } bram_t;

  resp_t       resp_q[$];
  bram_t       bram_q[$];
  resp_t       mon_r;
  bram_t       mon_b;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [63:0] last_rdata = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input string field,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: compare every BRAM accept and every response against the queues
  always @(negedge clk) begin
    if (bram_en) begin
      if (bram_q.size() == 0) begin
        chk("unexpected", "bram_en", {63'h0, bram_en}, 64'h0);
      end else begin
        mon_b = bram_q.pop_front();
        chk(mon_b.name, "bram_we", {56'h0, bram_we}, {56'h0, mon_b.we});
        chk(mon_b.name, "bram_addr", {50'h0, bram_addr}, {50'h0, mon_b.addr});
        if (mon_b.we != 8'h00) chk(mon_b.name, "bram_wdata", bram_wdata, mon_b.wdata);
        $display("bram  %-12s we=%h addr=%h wdata=%h", mon_b.name, bram_we, bram_addr, bram_wdata);
      end
    end
    if (mem_ready) begin
      if (resp_q.size() == 0) begin
        chk("unexpected", "mem_ready", {63'h0, mem_ready}, 64'h0);
      end else begin
        mon_r = resp_q.pop_front();
        chk(mon_r.name, "cpu_rdata", cpu_rdata, mon_r.rdata);
        chk(mon_r.name, "bus_err", {63'h0, bus_err}, {63'h0, mon_r.err});
        chk(mon_r.name, "ready_cycle", 64'(cyc), 64'(mon_r.cyc));
        $display("resp  %-12s rdata=%h err=%b cycle=%0d", mon_r.name, cpu_rdata, bus_err, cyc);
      end
    end
  end

  // Issue one request, queue its expectations and hold it until mem_ready
  task automatic xact(input string name, input logic re, input logic we,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [1:0] size, input logic uns,
                      input logic [63:0] exp_rdata, input logic exp_err, input int lat,
                      input logic exp_bram, input logic [7:0] exp_we,
                      input logic [63:0] exp_wlane);
    bram_t b;
    resp_t r;
    bit    done;
    @(posedge clk); #1;
    memory_re = re; memory_we = we; cpu_addr = addr; cpu_wdata = wdata;
    cpu_size = size; cpu_unsigned = uns;
    if (exp_bram) begin
      b.name = name; b.we = exp_we; b.addr = addr[16:3]; b.wdata = exp_wlane;
      bram_q.push_back(b);
    end
    r.name = name; r.rdata = exp_rdata; r.err = exp_err; r.cyc = cyc + lat;
    resp_q.push_back(r);
    last_rdata = exp_rdata;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (mem_ready) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: no mem_ready within 20 cycles, required one", name);
      if (resp_q.size() != 0) void'(resp_q.pop_back());
    end
    @(posedge clk); #1;
    memory_re = 1'b0; memory_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, "cpu_rdata", cpu_rdata, 64'h0);
    chk(name, "mem_ready", {63'h0, mem_ready}, 64'h0);
    chk(name, "bus_err", {63'h0, bus_err}, 64'h0);
    chk(name, "bram_en", {63'h0, bram_en}, 64'h0);
    chk(name, "bram_we", {56'h0, bram_we}, 64'h0);
    chk(name, "bram_addr", {50'h0, bram_addr}, 64'h0);
    chk(name, "bram_wdata", bram_wdata, 64'h0);
    chk(name, "led_out", {48'h0, led_out}, 64'h0);
  endtask

  initial begin
    bram_t b;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // BRAM dword store then load
    xact("st_d", 0, 1, 64'h40, 64'h1122334455667788, 2'd3, 0, last_rdata, 0, 1, 1, 8'hFF, 64'h1122334455667788);
    xact("ld_d", 1, 0, 64'h40, 64'h0, 2'd3, 0, 64'h1122334455667788, 0, RD_LAT+1, 1, 8'h00, 64'h0);
    // Byte store into lane 3, then signed/unsigned byte loads
    xact("st_b", 0, 1, 64'h43, 64'h80, 2'd0, 0, last_rdata, 0, 1, 1, 8'h08, 64'h0000_0000_8000_0000);
    xact("ld_bs", 1, 0, 64'h43, 64'h0, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, RD_LAT+1, 1, 8'h00, 64'h0);
    xact("ld_bu", 1, 0, 64'h43, 64'h0, 2'd0, 1, 64'h0000_0000_0000_0080, 0, RD_LAT+1, 1, 8'h00, 64'h0);
    // Word at 0x40 is now 0x1122334480667788
    xact("ld_hs", 1, 0, 64'h42, 64'h0, 2'd1, 0, 64'hFFFF_FFFF_FFFF_8066, 0, RD_LAT+1, 1, 8'h00, 64'h0);
    xact("ld_wu", 1, 0, 64'h44, 64'h0, 2'd2, 1, 64'h0000_0000_1122_3344, 0, RD_LAT+1, 1, 8'h00, 64'h0);
    xact("st_h", 0, 1, 64'h46, 64'hBEEF, 2'd1, 0, last_rdata, 0, 1, 1, 8'hC0, 64'hBEEF_0000_0000_0000);
    xact("ld_d2", 1, 0, 64'h40, 64'h0, 2'd3, 0, 64'hBEEF_3344_8066_7788, 0, RD_LAT+1, 1, 8'h00, 64'h0);
    // Faults: misaligned load/store, first address past BRAM
    xact("ld_w_mis", 1, 0, 64'h42, 64'h0, 2'd2, 0, 64'h0, 1, 1, 0, 8'h00, 64'h0);
    xact("ld_b_ok", 1, 0, 64'h43, 64'h0, 2'd0, 1, 64'h80, 0, RD_LAT+1, 1, 8'h00, 64'h0);
    xact("st_h_mis", 0, 1, 64'h45, 64'h1234, 2'd1, 0, 64'h0, 1, 1, 0, 8'h00, 64'h0);
    xact("ld_oob", 1, 0, 64'h2_0000, 64'h0, 2'd3, 0, 64'h0, 1, 1, 0, 8'h00, 64'h0);
    // Last BRAM dword
    xact("st_top", 0, 1, 64'h1_FFF8, 64'hCAFE_F00D_1234_5678, 2'd3, 0, last_rdata, 0, 1, 1, 8'hFF, 64'hCAFE_F00D_1234_5678);
    xact("ld_top", 1, 0, 64'h1_FFF8, 64'h0, 2'd3, 0, 64'hCAFE_F00D_1234_5678, 0, RD_LAT+1, 1, 8'h00, 64'h0);

`ifdef MEM_BRIDGE_MMIO_EN
    xact("st_led", 0, 1, 64'h1000_0000, 64'hA5A5, 2'd3, 0, last_rdata, 0, 1, 0, 8'h00, 64'h0);
    chk("st_led", "led_out", {48'h0, led_out}, 64'hA5A5);
    sw_in = 16'h00F0;
    repeat (3) @(posedge clk);
    xact("ld_sw", 1, 0, 64'h1000_0008, 64'h0, 2'd3, 0, 64'hF0, 0, 1, 0, 8'h00, 64'h0);
    xact("st_sw", 0, 1, 64'h1000_0008, 64'h1234, 2'd3, 0, last_rdata, 0, 1, 0, 8'h00, 64'h0);
    xact("ld_led", 1, 0, 64'h1000_0000, 64'h0, 2'd3, 0, 64'hA5A5, 0, 1, 0, 8'h00, 64'h0);
    xact("ld_mmio_bad", 1, 0, 64'h1000_0010, 64'h0, 2'd3, 0, 64'h0, 1, 1, 0, 8'h00, 64'h0);
`else
    sw_in = 16'h00F0;
    repeat (3) @(posedge clk);
    xact("ld_sw_off", 1, 0, 64'h1000_0008, 64'h0, 2'd3, 0, 64'h0, 1, 1, 0, 8'h00, 64'h0);
    xact("st_led_off", 0, 1, 64'h1000_0000, 64'hA5A5, 2'd3, 0, 64'h0, 1, 1, 0, 8'h00, 64'h0);
    chk("st_led_off", "led_out", {48'h0, led_out}, 64'h0);
`endif

    // Load and store together: store wins, no error
    xact("rw_pri", 1, 1, 64'h10, 64'hDEAD_BEEF_0BAD_F00D, 2'd3, 0, last_rdata, 0, 1, 1, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
    xact("ld_pri", 1, 0, 64'h10, 64'h0, 2'd3, 0, 64'hDEAD_BEEF_0BAD_F00D, 0, RD_LAT+1, 1, 8'h00, 64'h0);

    // Reset during RD_WAIT: load is accepted but never answered
    @(posedge clk); #1;
    memory_re = 1'b1; cpu_addr = 64'h40; cpu_size = 2'd3; cpu_unsigned = 1'b0;
    b.name = "ld_rst"; b.we = 8'h00; b.addr = 14'h8; b.wdata = 64'h0;
    bram_q.push_back(b);
    @(posedge clk); #2;
    rst = 1'b0;
    memory_re = 1'b0;
    #1;
    chk_reset_outputs("rst_rd_wait");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    last_rdata = 64'h0;
    repeat (2) @(posedge clk);
    xact("ld_after", 1, 0, 64'h40, 64'h0, 2'd3, 0, 64'hBEEF_3344_8066_7788, 0, RD_LAT+1, 1, 8'h00, 64'h0);

    repeat (4) @(posedge clk);
    chk("end", "resp_q_left", 64'(resp_q.size()), 64'h0);
    chk("end", "bram_q_left", 64'(bram_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- XLEN, 64, CPU data/address width
- BRAM_AW, 14, BRAM word-address width (8-byte words)
- RD_LAT, 2, BRAM read latency in cycles (1..3)
REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- memory_re  in  1  CPU load request
- memory_we  in  1  CPU store request
- cpu_addr  in  XLEN  byte address
- cpu_wdata  in  XLEN  store data, right-aligned (fed from cpu_main mem_out)
- cpu_size  in  2  0=byte, 1=half, 2=word, 3=dword
- cpu_unsigned  in  1  zero-extend load when 1
- cpu_rdata  out  XLEN  load data (drives cpu_main mem_in)
- mem_ready  out  1  one-cycle completion pulse
- bus_err  out  1  one-cycle fault pulse, coincident with mem_ready
- bram_en  out  1  BRAM enable
- bram_we  out  8  BRAM byte write strobes
- bram_addr  out  BRAM_AW  BRAM word address
- bram_wdata  out  64  BRAM write data, lane-aligned
- bram_rdata  in  64  BRAM read data
- led_out  out  16  LED register
- sw_in  in  16  raw board switches (asynchronous)

Function
REQ-003 SHALL implement FSM states IDLE, RD_WAIT, RESP.
REQ-004 SHALL accept a request only in IDLE; requests in other states are ignored, and the CPU holds them until mem_ready.
REQ-005 SHALL give memory_we priority when memory_re and memory_we are both high; the read is dropped and no error is flagged.
REQ-006 SHALL fault an access that is misaligned for its cpu_size, or that lies outside both BRAM (byte address below 2^(BRAM_AW+3)) and MMIO, as follows: no BRAM or MMIO side effect; RESP next cycle with mem_ready=1, bus_err=1, cpu_rdata=0.
REQ-007 SHALL, for a BRAM store, assert bram_en=1 and bram_we=strobes in the accept cycle, with data shifted to lane addr[2:0]; RESP follows next cycle (latency 1).
REQ-008 SHALL, for a BRAM load, assert bram_en=1 and bram_we=0 in the accept cycle; RD_WAIT counts RD_LAT-1 further cycles; then RESP, with bram_rdata extracted, shifted, and sign- or zero-extended into cpu_rdata.
REQ-009 SHALL raise mem_ready for exactly one cycle, in RESP only; RESP returns to IDLE unconditionally.
REQ-010 SHALL hold cpu_rdata until the next load or fault response; stores leave it unchanged.
REQ-011 SHALL decode MMIO at MMIO_BASE=0x1000_0000 as follows.
- +0x0 LED register: store writes bits[15:0]; load returns it zero-extended.
- +0x8 switches: read-only; stores are ignored without error.
- Any other MMIO offset faults.
- MMIO latency is 1 cycle for both loads and stores.
REQ-012 SHALL pass sw_in through a 2-flop synchronizer before it can be read.
REQ-013 SHALL hold bram_en and bram_we at 0 in every state except the accept cycle.

Reset
REQ-014 SHALL on rst low, asynchronously, enter IDLE and clear cpu_rdata, mem_ready, bus_err, bram_en, bram_we, bram_addr, bram_wdata, led_out, the synchronizer flops, and the latency counter.
REQ-015 SHALL abandon any in-flight access when rst asserts; no mem_ready is produced for it.

Configuration
REQ-016 SHALL gate MMIO with macro MEM_BRIDGE_MMIO_EN.
- Defined: MMIO behaves per REQ-011/012.
- Undefined: MMIO addresses fault per REQ-006, led_out is tied to 0, and sw_in is unused (no synchronizer flops).

Structure
REQ-017 SHALL place the size enum, the FSM state enum, MMIO_BASE, and the LED/switch offsets in package mem_bridge_pkg.
REQ-018 SHALL put the combinational alignment logic (strobe generation, store shift, load extract/extend, misalignment check) in sub-module mem_bridge_align.

Verification
REQ-019 SHALL cover these directed scenarios:
- Store dword 0x1122334455667788 @0x40, then load dword @0x40 -> store: bram_we=0xFF, mem_ready 1 cycle later; load: cpu_rdata=0x1122334455667788, mem_ready RD_LAT+1 cycles after accept.
- Store byte 0x80 @0x43, then load byte signed @0x43 -> bram_we=0x08, cpu_rdata=0xFFFFFFFFFFFFFF80; the same load unsigned -> 0x80.
- Load word @0x42 -> mem_ready=1, bus_err=1, cpu_rdata=0, no bram_en pulse.
- With MEM_BRIDGE_MMIO_EN: store 0xA5A5 @0x1000_0000 -> led_out=0xA5A5; sw_in=0x00F0 held 3 cycles, then load @0x1000_0008 -> cpu_rdata=0xF0. Without the macro, the same load -> bus_err=1.
- memory_re=memory_we=1 @0x10 -> a store only, bram_we!=0, bus_err=0. rst asserted during RD_WAIT -> no mem_ready, outputs at reset values, next request served normally.
